// File: rtl/dat_xfer_sequencer_if.sv
// Signal bundle between the SDHCI host logic, the DAT-line engines and dat_xfer_sequencer.
// Handshake: start is a one-cycle request taken only while busy is low. rd_start/wr_start hold
// until the cycle with sd_clk_en_p set, when the engine takes them. Engine done strobes,
// block_done and xfer_done are single-cycle pulses with no back-pressure.
interface dat_xfer_sequencer_if #(
    parameter int BlockCountWidth = 16,
    parameter int TimeoutWidth    = 24
);
    logic                       sd_clk_en_p;
    logic                       start;
    logic                       is_write;
    logic                       multi_block;
    logic [BlockCountWidth-1:0] block_count;
    logic [TimeoutWidth-1:0]    timeout;
    logic                       stop_at_gap;
    logic                       continue_gap;
    logic                       abort;
    logic                       buf_ready;
    logic                       rd_start;
    logic                       wr_start;
    logic                       rd_data_valid;
    logic                       rd_done;
    logic                       rd_crc_err;
    logic                       rd_end_bit_err;
    logic                       wr_done;
    logic                       wr_crc_err;
    logic                       wr_end_bit_err;
    logic                       dat0;
    logic                       pause_sd_clk;
    logic                       busy;
    logic                       block_gap;
    logic                       block_done;
    logic                       xfer_done;
    logic [BlockCountWidth-1:0] blocks_left;
    logic                       err_timeout;
    logic                       err_crc;
    logic                       err_end_bit;
    logic [3:0]                 state;

    modport slave (
        input  sd_clk_en_p, start, is_write, multi_block, block_count, timeout,
        input  stop_at_gap, continue_gap, abort, buf_ready,
        input  rd_data_valid, rd_done, rd_crc_err, rd_end_bit_err,
        input  wr_done, wr_crc_err, wr_end_bit_err, dat0,
        output rd_start, wr_start, pause_sd_clk, busy, block_gap, block_done,
        output xfer_done, blocks_left, err_timeout, err_crc, err_end_bit, state
    );

    modport master (
        output sd_clk_en_p, start, is_write, multi_block, block_count, timeout,
        output stop_at_gap, continue_gap, abort, buf_ready,
        output rd_data_valid, rd_done, rd_crc_err, rd_end_bit_err,
        output wr_done, wr_crc_err, wr_end_bit_err, dat0,
        input  rd_start, wr_start, pause_sd_clk, busy, block_gap, block_done,
        input  xfer_done, blocks_left, err_timeout, err_crc, err_end_bit, state
    );
endinterface

// File: rtl/dat_xfer_sequencer.sv
// Block-level sequencer for SD DAT transfers: issues per-block engine starts, counts blocks,
// enforces data/busy timeouts and parks at block gaps when the buffer or host asks it to.
module dat_xfer_sequencer #(
    parameter int BlockCountWidth = 16,
    parameter int TimeoutWidth    = 24
) (
    input logic                 clk,
    input logic                 rst_n,
    dat_xfer_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WAIT_BUF = 4'd1,
        S_START    = 4'd2,
        S_RD_WAIT  = 4'd3,
        S_WR_WAIT  = 4'd4,
        S_WR_BUSY  = 4'd5,
        S_GAP      = 4'd6,
        S_GAP_STOP = 4'd7,
        S_ERR      = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic                       is_write_q;
    logic [BlockCountWidth-1:0] blocks_left_q;
    logic [TimeoutWidth-1:0]    tmo_cnt_q;
    logic                       err_timeout_q;
    logic                       err_crc_q;
    logic                       err_end_bit_q;
    logic                       block_done_q;

    logic [BlockCountWidth-1:0] eff_count;
    logic                       accept_start;
    logic                       tmo_hit;
    logic                       rd_err;
    logic                       wr_err;

    logic                       ev_block_ok;
    logic                       ev_timeout;
    logic                       ev_set_crc;
    logic                       ev_set_end_bit;
    logic                       cnt_clear;
    logic                       cnt_inc;

    assign eff_count    = bus.multi_block ? bus.block_count : BlockCountWidth'(1);
    assign accept_start = (state_q == S_IDLE) && bus.start;
    assign tmo_hit      = (bus.timeout != '0) && (tmo_cnt_q == bus.timeout);
    assign rd_err       = bus.rd_crc_err | bus.rd_end_bit_err;
    assign wr_err       = bus.wr_crc_err | bus.wr_end_bit_err;

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort outranks everything; an engine done outranks a timeout seen in the same cycle.
    always_comb begin : next_state
        state_d        = state_q;
        ev_block_ok    = 1'b0;
        ev_timeout     = 1'b0;
        ev_set_crc     = 1'b0;
        ev_set_end_bit = 1'b0;
        cnt_clear      = 1'b0;
        cnt_inc        = 1'b0;
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        cnt_clear = 1'b1;
                        state_d   = (eff_count == '0) ? S_DONE : S_WAIT_BUF;
                    end
                end
                S_WAIT_BUF: begin
                    if (bus.buf_ready) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (bus.sd_clk_en_p) begin
                        cnt_clear = 1'b1;
                        state_d   = is_write_q ? S_WR_WAIT : S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    cnt_inc   = bus.sd_clk_en_p;
                    cnt_clear = bus.rd_data_valid;
                    if (bus.rd_done) begin
                        if (rd_err) begin
                            ev_set_crc     = bus.rd_crc_err;
                            ev_set_end_bit = bus.rd_end_bit_err;
                            state_d        = S_ERR;
                        end else begin
                            ev_block_ok = 1'b1;
                            state_d     = S_GAP;
                        end
                    end else if (tmo_hit) begin
                        ev_timeout = 1'b1;
                        state_d    = S_ERR;
                    end
                end
                S_WR_WAIT: begin
                    cnt_inc = bus.sd_clk_en_p;
                    if (bus.wr_done) begin
                        if (wr_err) begin
                            ev_set_crc     = bus.wr_crc_err;
                            ev_set_end_bit = bus.wr_end_bit_err;
                            state_d        = S_ERR;
                        end else begin
                            cnt_clear = 1'b1;
                            state_d   = S_WR_BUSY;
                        end
                    end else if (tmo_hit) begin
                        ev_timeout = 1'b1;
                        state_d    = S_ERR;
                    end
                end
                S_WR_BUSY: begin
                    // The card releases DAT0 when programming finishes; only look on SD clock edges.
                    cnt_inc = bus.sd_clk_en_p;
                    if (bus.sd_clk_en_p && bus.dat0) begin
                        ev_block_ok = 1'b1;
                        state_d     = S_GAP;
                    end else if (tmo_hit) begin
                        ev_timeout = 1'b1;
                        state_d    = S_ERR;
                    end
                end
                S_GAP: begin
                    if (blocks_left_q == '0) begin
                        state_d = S_DONE;
                    end else if (bus.stop_at_gap) begin
                        state_d = S_GAP_STOP;
                    end else begin
                        state_d = S_WAIT_BUF;
                    end
                end
                S_GAP_STOP: begin
                    if (bus.continue_gap) begin
                        state_d = S_WAIT_BUF;
                    end
                end
                S_ERR:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin : outputs
        bus.rd_start     = 1'b0;
        bus.wr_start     = 1'b0;
        bus.pause_sd_clk = 1'b0;
        bus.block_gap    = 1'b0;
        bus.xfer_done    = 1'b0;
        bus.busy         = (state_q != S_IDLE);
        case (state_q)
            S_WAIT_BUF: bus.pause_sd_clk = !bus.buf_ready;
            S_START: begin
                bus.rd_start = !is_write_q;
                bus.wr_start = is_write_q;
            end
            S_GAP_STOP: begin
                bus.block_gap    = 1'b1;
                bus.pause_sd_clk = 1'b1;
            end
            S_DONE:  bus.xfer_done = 1'b1;
            default: ;
        endcase
        bus.block_done  = block_done_q;
        bus.blocks_left = blocks_left_q;
        bus.err_timeout = err_timeout_q;
        bus.err_crc     = err_crc_q;
        bus.err_end_bit = err_end_bit_q;
        bus.state       = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin : datapath
        if (!rst_n) begin
            is_write_q    <= 1'b0;
            blocks_left_q <= '0;
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
            err_crc_q     <= 1'b0;
            err_end_bit_q <= 1'b0;
            block_done_q  <= 1'b0;
        end else begin
            block_done_q <= ev_block_ok;
            if (accept_start) begin
                is_write_q    <= bus.is_write;
                blocks_left_q <= eff_count;
                err_timeout_q <= 1'b0;
                err_crc_q     <= 1'b0;
                err_end_bit_q <= 1'b0;
            end else if (ev_block_ok) begin
                blocks_left_q <= blocks_left_q - BlockCountWidth'(1);
            end
            if (ev_timeout) begin
                err_timeout_q <= 1'b1;
            end
            if (ev_set_crc) begin
                err_crc_q <= 1'b1;
            end
            if (ev_set_end_bit) begin
                err_end_bit_q <= 1'b1;
            end
            // Saturating so a long-stalled card cannot wrap back under the limit.
            if (cnt_clear) begin
                tmo_cnt_q <= '0;
            end else if (cnt_inc && (tmo_cnt_q != '1)) begin
                tmo_cnt_q <= tmo_cnt_q + TimeoutWidth'(1);
            end
        end
    end
endmodule
